// File: rtl/complex_dp_pkg.sv
// Shared types and constants for the complex dot-product feeder.
package complex_dp_pkg;

    // Feeder sequencing states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_LOAD,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT_FINISH,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Sticky fault codes reported on the error port.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TOTAL   = 2'd1;
    localparam logic [1:0] ERR_READY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A 64-bit complex element: real part in the upper half.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    function automatic cplx_t split_element(input logic [63:0] element);
        cplx_t c;
        c.re = element[63:32];
        c.im = element[31:0];
        return c;
    endfunction

endpackage

// File: rtl/complex_dot_product_feeder_if.sv
// Request, row-memory, engine and result signals of one feeder.
interface complex_dot_product_feeder_if #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 10
);
    localparam int row_width = element_width * no_of_units;

    logic                     start;
    logic [31:0]              total;
    logic [addr_width-1:0]    base_a;
    logic [addr_width-1:0]    base_b;
    logic                     mem_rd_en;
    logic [addr_width-1:0]    mem_addr_a;
    logic [addr_width-1:0]    mem_addr_b;
    logic [row_width-1:0]     mem_rd_data_a;
    logic [row_width-1:0]     mem_rd_data_b;
    logic [row_width-1:0]     first_row_out;
    logic [row_width-1:0]     second_row_out;
    logic                     read_now;
    logic                     engine_reset;
    logic                     engine_ready;
    logic                     engine_finish;
    logic [element_width-1:0] engine_result;
    logic [element_width-1:0] result;
    logic                     result_valid;
    logic                     result_ack;
    logic                     busy;
    logic [1:0]               error;

    // The feeder itself.
    modport master (
        input  start, total, base_a, base_b, mem_rd_data_a, mem_rd_data_b,
               engine_ready, engine_finish, engine_result, result_ack,
        output mem_rd_en, mem_addr_a, mem_addr_b, first_row_out, second_row_out,
               read_now, engine_reset, result, result_valid, busy, error
    );

    // Everything around the feeder: requester, row memories and engine.
    modport slave (
        output start, total, base_a, base_b, mem_rd_data_a, mem_rd_data_b,
               engine_ready, engine_finish, engine_result, result_ack,
        input  mem_rd_en, mem_addr_a, mem_addr_b, first_row_out, second_row_out,
               read_now, engine_reset, result, result_valid, busy, error
    );

endinterface

// File: rtl/complex_package_fetch.sv
// Row-package fetch path: address counters, read strobe and row registers.
module complex_package_fetch #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                load_base,
    input  logic [addr_width-1:0]               base_a,
    input  logic [addr_width-1:0]               base_b,
    input  logic                                rd_req,
    input  logic                                capture,
    input  logic                                advance,
    input  logic [element_width*no_of_units-1:0] mem_rd_data_a,
    input  logic [element_width*no_of_units-1:0] mem_rd_data_b,
    output logic                                mem_rd_en,
    output logic [addr_width-1:0]               mem_addr_a,
    output logic [addr_width-1:0]               mem_addr_b,
    output logic [element_width*no_of_units-1:0] first_row_out,
    output logic [element_width*no_of_units-1:0] second_row_out
);
    localparam logic [addr_width-1:0] addr_one = 1;

    // The strobe is the READ state itself; data returns one cycle later.
    assign mem_rd_en = rd_req;

    // Address counters: load bases on accept, step after each package, wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!reset) begin
            mem_addr_a <= '0;
            mem_addr_b <= '0;
        end else if (load_base) begin
            mem_addr_a <= base_a;
            mem_addr_b <= base_b;
        end else if (advance) begin
            mem_addr_a <= mem_addr_a + addr_one;
            mem_addr_b <= mem_addr_b + addr_one;
        end
    end

    // Row registers change only in LOAD so the engine sees stable halves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_row_out  <= '0;
            second_row_out <= '0;
        end else if (capture) begin
            first_row_out  <= mem_rd_data_a;
            second_row_out <= mem_rd_data_b;
        end
    end

endmodule

// File: rtl/complex_dot_product_feeder.sv
// Sequencer feeding row-package pairs to the complex dot-product engine.
module complex_dot_product_feeder
    import complex_dp_pkg::*;
#(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int addr_width    = 10,
    parameter int PKG_GAP       = 2,
    parameter int TIMEOUT       = 1023
) (
    input logic                          clk,
    input logic                          reset,
    complex_dot_product_feeder_if.master bus
);
    localparam int cnt_max   = (TIMEOUT > PKG_GAP) ? TIMEOUT : PKG_GAP;
    localparam int cnt_width = $clog2(cnt_max + 1);
    localparam logic [cnt_width-1:0] cnt_one    = 1;
    localparam logic [cnt_width-1:0] clear_last = 1;
    localparam logic [cnt_width-1:0] hold_last  = cnt_width'(PKG_GAP - 1);
    localparam logic [cnt_width-1:0] wait_last  = cnt_width'(TIMEOUT - 1);

    state_t                   state;
    state_t                   state_next;
    logic [cnt_width-1:0]     cnt;
    logic [31:0]              remaining;
    logic [1:0]               error_q;
    logic [1:0]               error_next;
    logic [element_width-1:0] result_q;
    logic                     result_valid_q;
    logic                     start_ok;
    logic                     accept;
    logic                     advance;

    assign start_ok = (bus.total != '0) && ((bus.total % 32'(no_of_units)) == '0);
    assign accept   = bus.start && start_ok && (state == ST_IDLE || state == ST_ERROR);
    assign advance  = (state == ST_HOLD) && (cnt == hold_last);

    assign bus.engine_reset = (state == ST_CLEAR);
    assign bus.read_now     = (state == ST_PULSE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.error        = error_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and fault-code decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_next = state;
        error_next = error_q;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (start_ok) begin
                        state_next = ST_CLEAR;
                    end else begin
                        state_next = ST_ERROR;
                        error_next = ERR_TOTAL;
                    end
                end
            end
            ST_CLEAR: if (cnt == clear_last) state_next = ST_READ;
            ST_READ:  state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_PULSE;
            ST_PULSE: state_next = ST_HOLD;
            ST_HOLD: begin
                if (cnt == '0 && !bus.engine_ready) begin
                    state_next = ST_ERROR;
                    error_next = ERR_READY;
                end else if (cnt == hold_last) begin
                    state_next = (remaining == '0) ? ST_WAIT_FINISH : ST_READ;
                end
            end
            ST_WAIT_FINISH: begin
                if (bus.engine_finish) begin
                    state_next = ST_DONE;
                end else if (cnt == wait_last) begin
                    state_next = ST_ERROR;
                    error_next = ERR_TIMEOUT;
                end
            end
            ST_DONE: if (bus.result_ack) state_next = ST_IDLE;
            ST_ERROR: begin
                if (bus.start) begin
                    if (start_ok) begin
                        state_next = ST_CLEAR;
                        error_next = ERR_NONE;
                    end else begin
                        error_next = ERR_TOTAL;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Phase counter, package count, fault code and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            remaining      <= '0;
            error_q        <= ERR_NONE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            cnt     <= (state_next != state) ? '0 : cnt + cnt_one;
            error_q <= error_next;
            if (accept)
                remaining <= bus.total / 32'(no_of_units);
            else if (state == ST_PULSE)
                remaining <= remaining - 32'd1;
            if (state == ST_WAIT_FINISH && bus.engine_finish) begin
                result_q       <= bus.engine_result;
                result_valid_q <= 1'b1;
            end else if (state == ST_DONE && bus.result_ack) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    complex_package_fetch #(
        .element_width(element_width),
        .no_of_units  (no_of_units),
        .addr_width   (addr_width)
    ) u_fetch (
        .clk           (clk),
        .reset         (reset),
        .load_base     (accept),
        .base_a        (bus.base_a),
        .base_b        (bus.base_b),
        .rd_req        (state == ST_READ),
        .capture       (state == ST_LOAD),
        .advance       (advance),
        .mem_rd_data_a (bus.mem_rd_data_a),
        .mem_rd_data_b (bus.mem_rd_data_b),
        .mem_rd_en     (bus.mem_rd_en),
        .mem_addr_a    (bus.mem_addr_a),
        .mem_addr_b    (bus.mem_addr_b),
        .first_row_out (bus.first_row_out),
        .second_row_out(bus.second_row_out)
    );

endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Directed bench for the complex dot-product feeder with memory and engine models.
module tb_complex_dot_product_feeder;
    import complex_dp_pkg::*;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 10;
    localparam int RW = EW * NU;
    localparam logic [EW-1:0] ENGINE_VALUE = 64'h0000_0005_0000_0003;

    typedef logic [511:0] val_t;

    logic clk;
    logic reset;
    int   cyc;
    int   start_cyc;
    int   n_checks;
    int   n_pass;

    int            strobe_cyc[$];
    logic [RW-1:0] row_a_at[$];
    logic [AW-1:0] rd_addr_a[$];
    logic [AW-1:0] rd_addr_b[$];

    complex_dot_product_feeder_if #(.element_width(EW), .no_of_units(NU), .addr_width(AW)) bus ();

    complex_dot_product_feeder #(
        .element_width(EW), .no_of_units(NU), .addr_width(AW), .PKG_GAP(2), .TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] pattern_a(input logic [AW-1:0] a);
        return {NU{64'hA5A5_0000_0000_0000 | 64'(a)}};
    endfunction

    function automatic logic [RW-1:0] pattern_b(input logic [AW-1:0] a);
        return {NU{64'h5B5B_0000_0000_0000 | 64'(a)}};
    endfunction

    // Synchronous-read row memories.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data_a <= pattern_a(bus.mem_addr_a);
            bus.mem_rd_data_b <= pattern_b(bus.mem_addr_b);
        end
    end

    // Log every read strobe and package strobe.
    always @(negedge clk) begin
        if (bus.read_now) begin
            strobe_cyc.push_back(cyc);
            row_a_at.push_back(bus.first_row_out);
        end
        if (bus.mem_rd_en) begin
            rd_addr_a.push_back(bus.mem_addr_a);
            rd_addr_b.push_back(bus.mem_addr_b);
        end
    end

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        strobe_cyc.delete();
        row_a_at.delete();
        rd_addr_a.delete();
        rd_addr_b.delete();
    endtask

    // One-cycle start; returns at the negedge just after the sampling edge.
    task automatic do_start(input int tot, input int ba, input int bb);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.total  = 32'(tot);
        bus.base_a = AW'(ba);
        bus.base_b = AW'(bb);
        @(negedge clk);
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int waited = 0;
        while (strobe_cyc.size() < n && waited < budget) begin
            @(posedge clk);
            waited++;
        end
        check("strobe_count", val_t'(strobe_cyc.size()), val_t'(n));
    endtask

    // Called at the edge ending the last PULSE: check rows in HOLD, then raise finish.
    task automatic finish_engine(input logic [RW-1:0] ra, input logic [RW-1:0] rb);
        @(negedge clk);
        @(negedge clk);
        check("row_a_hold", bus.first_row_out, ra);
        check("row_b_hold", bus.second_row_out, rb);
        @(negedge clk);
        bus.engine_finish = 1'b1;
        @(negedge clk);
        bus.engine_finish = 1'b0;
        check("result_valid_rise", val_t'(bus.result_valid), val_t'(1));
        check("result_value", val_t'(bus.result), val_t'(ENGINE_VALUE));
        check("error_clean", val_t'(bus.error), val_t'(ERR_NONE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        reset    = 1'b0;
        bus.start = 1'b0;
        bus.total = '0;
        bus.base_a = '0;
        bus.base_b = '0;
        bus.result_ack = 1'b0;
        bus.engine_ready = 1'b1;
        bus.engine_finish = 1'b0;
        bus.engine_result = ENGINE_VALUE;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", val_t'(bus.busy), val_t'(0));
        check("rst_error", val_t'(bus.error), val_t'(0));
        check("rst_read_now", val_t'(bus.read_now), val_t'(0));
        check("rst_rd_en", val_t'(bus.mem_rd_en), val_t'(0));
        check("rst_valid", val_t'(bus.result_valid), val_t'(0));
        check("rst_row_a", bus.first_row_out, '0);
        reset = 1'b1;

        // Nominal two-package run.
        clear_logs();
        do_start(16, 0, 'h20);
        check("clear_c0", val_t'(bus.engine_reset), val_t'(1));
        check("busy_c0", val_t'(bus.busy), val_t'(1));
        @(negedge clk);
        check("clear_c1", val_t'(bus.engine_reset), val_t'(1));
        @(negedge clk);
        check("clear_end", val_t'(bus.engine_reset), val_t'(0));
        check("read_c2", val_t'(bus.mem_rd_en), val_t'(1));
        wait_strobes(2, 40);
        finish_engine(pattern_a(1), pattern_b('h21));
        check("result_re", val_t'(split_element(bus.result).re), val_t'(5));
        check("first_latency", val_t'(strobe_cyc[0] - start_cyc), val_t'(4));
        check("pkg_period", val_t'(strobe_cyc[1] - strobe_cyc[0]), val_t'(5));
        check("addr_a0", val_t'(rd_addr_a[0]), val_t'(0));
        check("addr_b0", val_t'(rd_addr_b[0]), val_t'('h20));
        check("addr_a1", val_t'(rd_addr_a[1]), val_t'(1));
        check("addr_b1", val_t'(rd_addr_b[1]), val_t'('h21));
        check("row_a_strobe0", row_a_at[0], pattern_a(0));
        // Ack together with start: exit to IDLE, start not accepted.
        bus.result_ack = 1'b1;
        bus.start = 1'b1;
        bus.total = 32'd16;
        @(negedge clk);
        bus.result_ack = 1'b0;
        bus.start = 1'b0;
        check("ack_valid_low", val_t'(bus.result_valid), val_t'(0));
        check("ack_idle", val_t'(bus.busy), val_t'(0));
        repeat (6) @(negedge clk);
        check("ack_start_ignored", val_t'(rd_addr_a.size()), val_t'(2));

        // Bad total.
        clear_logs();
        do_start(12, 0, 0);
        check("bad_total_err", val_t'(bus.error), val_t'(ERR_TOTAL));
        check("bad_total_busy", val_t'(bus.busy), val_t'(1));
        repeat (8) @(negedge clk);
        check("bad_total_no_rd", val_t'(rd_addr_a.size()), val_t'(0));
        check("bad_total_no_strobe", val_t'(strobe_cyc.size()), val_t'(0));

        // Missing ready echo.
        clear_logs();
        bus.engine_ready = 1'b0;
        do_start(16, 0, 'h20);
        repeat (5) @(negedge clk);
        check("ready_err_cleared", val_t'(bus.error), val_t'(ERR_NONE));
        @(negedge clk);
        check("ready_err", val_t'(bus.error), val_t'(ERR_READY));
        repeat (12) @(negedge clk);
        check("ready_one_strobe", val_t'(strobe_cyc.size()), val_t'(1));
        bus.engine_ready = 1'b1;

        // Timeout after 15 cycles in WAIT_FINISH.
        clear_logs();
        do_start(8, 0, 0);
        repeat (21) @(negedge clk);
        check("timeout_pre", val_t'(bus.error), val_t'(ERR_NONE));
        @(negedge clk);
        check("timeout_err", val_t'(bus.error), val_t'(ERR_TIMEOUT));

        // Asynchronous reset between the second and third strobes.
        clear_logs();
        do_start(64, 0, 0);
        wait_strobes(2, 40);
        #2 reset = 1'b0;
        #1;
        check("ar_busy", val_t'(bus.busy), val_t'(0));
        check("ar_row_a", bus.first_row_out, '0);
        check("ar_result", val_t'(bus.result), val_t'(0));
        check("ar_addr_a", val_t'(bus.mem_addr_a), val_t'(0));
        check("ar_read_now", val_t'(bus.read_now), val_t'(0));
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        do_start(8, 5, 6);
        wait_strobes(1, 30);
        finish_engine(pattern_a(5), pattern_b(6));
        check("ar_single_strobe", val_t'(strobe_cyc.size()), val_t'(1));
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check("ar_ack", val_t'(bus.result_valid), val_t'(0));

        // Address wrap and held result with a start to ignore.
        clear_logs();
        do_start(16, (1 << AW) - 1, 0);
        wait_strobes(2, 40);
        finish_engine(pattern_a(0), pattern_b(1));
        check("wrap_addr_a0", val_t'(rd_addr_a[0]), val_t'((1 << AW) - 1));
        check("wrap_addr_a1", val_t'(rd_addr_a[1]), val_t'(0));
        check("wrap_addr_b1", val_t'(rd_addr_b[1]), val_t'(1));
        check("wrap_row_a1", row_a_at[1], pattern_a(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus.start = 1'b1;
                bus.total = 32'd16;
            end
            if (i == 4) bus.start = 1'b0;
            check("hold_valid", val_t'(bus.result_valid), val_t'(1));
        end
        check("hold_no_rd", val_t'(rd_addr_a.size()), val_t'(2));
        bus.result_ack = 1'b1;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check("hold_ack", val_t'(bus.result_valid), val_t'(0));
        repeat (5) @(negedge clk);
        check("hold_idle", val_t'(bus.busy), val_t'(0));
        check("hold_no_new_rd", val_t'(rd_addr_a.size()), val_t'(2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
